// File: rtl/aer_pkg.sv
// rtl/aer_pkg.sv - shared types and helpers for the AER row arbiter
package aer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        WAIT_ACK = 2'd2,
        WAIT_REL = 2'd3
    } aer_state_e;

    // Address width that stays at least one bit for tiny arrays
    function automatic int aw_calc(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/aer_rr_picker.sv
// rtl/aer_rr_picker.sv - combinational round-robin / fixed-priority winner select
module aer_rr_picker
    import aer_pkg::*;
#(
    parameter int N = 12,
    parameter int W = aw_calc(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         greedy,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         valid
);

    int j;

    always_comb begin
        idx   = '0;
        j     = 0;
        valid = |req;
        if (greedy) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) idx = W'(i);
            end
        end else begin
            // Scan from farthest to nearest so the first row above ptr lands last
            for (int k = N; k >= 1; k--) begin
                j = (int'(ptr) + k) % N;
                if (req[j]) idx = W'(j);
            end
        end
        grant = valid ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/aer_sync_cell.sv
// rtl/aer_sync_cell.sv - multi-flop synchroniser for a single asynchronous bit
module aer_sync_cell #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/aer_row_arb_sync.sv
// rtl/aer_row_arb_sync.sv - clocked AER row arbiter with 4-phase REQ/ACK handshake
module aer_row_arb_sync
    import aer_pkg::*;
#(
    parameter int NROWS       = 12,
    parameter int AW          = aw_calc(NROWS),
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NROWS-1:0] N_P,
    input  logic             ACK,
    input  logic             GREEDY,
    input  logic             AER_DIS,
    input  logic [NROWS-1:0] ROW_MASK,
    input  logic [NROWS-2:0] S_EXT,
    output logic             REQ,
    output logic [AW-1:0]    ADDRY,
    output logic [NROWS-1:0] S,
    output logic             BUSY,
    output logic             TO_ERR,
    output logic [CNT_W-1:0] EVT_CNT
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    logic [NROWS-1:0] np_s;
    logic             ack_s;
    logic [NROWS-1:0] req_vec;
    logic [NROWS-1:0] pick_grant;
    logic [AW-1:0]    pick_idx;
    logic             pick_valid;
    logic             timeout_hit;

    aer_state_e       state_q, state_n;
    logic             req_q, req_n;
    logic [NROWS-1:0] sel_q, sel_n;
    logic [AW-1:0]    addry_q, addry_n;
    logic [AW-1:0]    ptr_q, ptr_n;
    logic [TW-1:0]    timer_q, timer_n;
    logic             to_err_q, to_err_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    for (genvar g = 0; g < NROWS; g++) begin : g_np_sync
        aer_sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_np_sync (
            .clk (CLK),
            .rst (RST),
            .d   (N_P[g]),
            .q   (np_s[g])
        );
    end

    aer_sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ack_sync (
        .clk (CLK),
        .rst (RST),
        .d   (ACK),
        .q   (ack_s)
    );

    assign req_vec = ~np_s & ~ROW_MASK;

    aer_rr_picker #(.N(NROWS), .W(AW)) u_picker (
        .req    (req_vec),
        .ptr    (ptr_q),
        .greedy (GREEDY),
        .grant  (pick_grant),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Timer counts cycles spent in WAIT_ACK plus WAIT_REL combined
    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TO_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            sel_q    <= '0;
            addry_q  <= '0;
            ptr_q    <= AW'(NROWS - 1);
            timer_q  <= '0;
            to_err_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_n;
            req_q    <= req_n;
            sel_q    <= sel_n;
            addry_q  <= addry_n;
            ptr_q    <= ptr_n;
            timer_q  <= timer_n;
            to_err_q <= to_err_n;
            cnt_q    <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        req_n    = req_q;
        sel_n    = sel_q;
        addry_n  = addry_q;
        ptr_n    = ptr_q;
        timer_n  = timer_q;
        to_err_n = 1'b0;
        cnt_n    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!AER_DIS && pick_valid) begin
                    sel_n   = pick_grant;
                    addry_n = pick_idx;
                    if (!GREEDY) ptr_n = pick_idx;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                req_n   = 1'b1;
                timer_n = '0;
                state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                // ACK is checked first so it beats a same-cycle timeout
                if (ack_s) begin
                    req_n   = 1'b0;
                    sel_n   = '0;
                    cnt_n   = cnt_q + 1'b1;
                    state_n = WAIT_REL;
                end else if (timeout_hit) begin
                    req_n    = 1'b0;
                    sel_n    = '0;
                    to_err_n = 1'b1;
                    state_n  = IDLE;
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end
            WAIT_REL: begin
                if (!ack_s) begin
                    state_n = IDLE;
                end else if (timeout_hit) begin
                    to_err_n = 1'b1;
                    state_n  = IDLE;
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign REQ     = req_q;
    assign ADDRY   = addry_q;
    assign S       = sel_q | {1'b0, S_EXT};
    assign BUSY    = (state_q != IDLE);
    assign TO_ERR  = to_err_q;
    assign EVT_CNT = cnt_q;

endmodule
